// File: rtl/hit_time_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hit_time_buffer_pkg
//  Purpose  : Shared layout of a hit-time word,
//             {ltc[31:0], sample index[1:0], sub-sample[PRECISION-1:0]}.
//             Used by the hit buffer and by the CFD time extractor.
//  Contents : field widths, field offset helpers, TBITS helper
//  Revision : 1.0  initial release
// ============================================================================
package hit_time_buffer_pkg;

  localparam int LTC_W   = 32;
  localparam int IDX_W   = 2;
  localparam int SUB_LSB = 0;

  // The sample index sits directly above the sub-sample bits.
  function automatic int idx_lsb(input int precision);
    return precision;
  endfunction

  // Offset of the LTC field, i.e. PRECISION+2.
  function automatic int ltc_lsb(input int precision);
    return precision + IDX_W;
  endfunction

  // Full hit-time width for a given sub-sample precision.
  function automatic int tbits(input int precision);
    return LTC_W + IDX_W + precision;
  endfunction

endpackage : hit_time_buffer_pkg
`default_nettype wire

// File: rtl/hit_time_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO storage with a registered memory array and
//             separate read/write pointers. The read port is combinational
//             from the head entry, so the consumer can register it directly.
//  Ports    : clk, reset_n      clock, async active-low reset
//             i_wr_en/i_wr_data write request (ignored while full)
//             i_rd_en           pop the head entry (ignored while empty)
//             o_rd_data         head entry
//             o_empty           no entries stored
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int                    c_depth   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_full    = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [DEPTH_LOG2:0]   c_cnt_one = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_wr;
  logic w_rd;

  assign o_empty   = (r_count == '0);
  assign w_wr      = i_wr_en && (r_count != c_full);
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Memory contents need no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/hit_time_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : hit_time_buffer
//  Purpose  : Buffers hit times from the CFD extractor. Applies an LTC
//             deadtime filter, stores accepted hits in a FIFO and presents
//             them through a first-word-fall-through output register.
//  Ports    : clk, reset_n      clock, async active-low reset
//             valid_in, t_in    incoming hit strobe and hit time
//             m_ready           downstream ready
//             clr               sync clear of counters and overflow flag
//             m_valid, m_data   head-of-buffer word
//             count             words held, including the output register
//             overflow          sticky: a hit was lost to a full buffer
//             n_dropped         saturating count of hits lost to full
//             n_deadtime        saturating count of deadtime rejects
//  Revision : 1.0  initial release
// ============================================================================
module hit_time_buffer
  import hit_time_buffer_pkg::*;
#(
  parameter int PRECISION  = 4,
  parameter int TBITS      = tbits(PRECISION),
  parameter int DEPTH_LOG2 = 4,
  parameter int DEADTIME   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_in,
  input  logic [TBITS-1:0]      t_in,
  input  logic                  m_ready,
  input  logic                  clr,
  output logic                  m_valid,
  output logic [TBITS-1:0]      m_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [15:0]           n_dropped,
  output logic [15:0]           n_deadtime
);

  localparam int                  c_ltc_lsb  = ltc_lsb(PRECISION);
  localparam logic [DEPTH_LOG2:0] c_full     = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] c_cnt_one  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [LTC_W-1:0]    c_deadtime = LTC_W'(DEADTIME);

  logic                  r_armed;
  logic                  r_have_last;
  logic [LTC_W-1:0]      r_last_ltc;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_m_valid;
  logic [TBITS-1:0]      r_m_data;
  logic                  r_overflow;
  logic [15:0]           r_n_dropped;
  logic [15:0]           r_n_deadtime;

  logic [LTC_W-1:0]      w_ltc;
  logic [LTC_W-1:0]      w_delta;
  logic                  w_dt_ok;
  logic                  w_hit;
  logic                  w_full;
  logic                  w_acc;
  logic                  w_drop;
  logic                  w_dt_rej;
  logic                  w_load;
  logic                  w_xfer;
  logic [TBITS-1:0]      w_fifo_data;
  logic                  w_fifo_empty;

  // Modular subtraction handles LTC wrap-around naturally.
  assign w_ltc    = t_in[TBITS-1:c_ltc_lsb];
  assign w_delta  = w_ltc - r_last_ltc;
  assign w_dt_ok  = !r_have_last || (DEADTIME == 0) || (w_delta >= c_deadtime);

  // r_armed masks the first edge after reset release.
  assign w_hit    = valid_in && r_armed;
  // Full uses the pre-edge count, so a same-edge read never frees a slot.
  assign w_full   = (r_count == c_full);
  assign w_dt_rej = w_hit && !w_dt_ok;
  assign w_drop   = w_hit && w_dt_ok && w_full;
  assign w_acc    = w_hit && w_dt_ok && !w_full;

  // Refill the output register whenever it is empty or being consumed.
  assign w_xfer   = r_m_valid && m_ready;
  assign w_load   = !w_fifo_empty && (!r_m_valid || m_ready);

  sync_fifo #(
    .WIDTH      (TBITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_acc),
    .i_wr_data (t_in),
    .i_rd_en   (w_load),
    .o_rd_data (w_fifo_data),
    .o_empty   (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed      <= 1'b0;
      r_have_last  <= 1'b0;
      r_last_ltc   <= '0;
      r_count      <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_overflow   <= 1'b0;
      r_n_dropped  <= '0;
      r_n_deadtime <= '0;
    end else begin
      r_armed <= 1'b1;

      // Only accepted hits restart the deadtime window.
      if (w_acc) begin
        r_last_ltc  <= w_ltc;
        r_have_last <= 1'b1;
      end

      unique case ({w_acc, w_xfer})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase

      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_fifo_data;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      if (clr) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end

      if (clr) begin
        r_n_dropped <= '0;
      end else if (w_drop && (r_n_dropped != 16'hFFFF)) begin
        r_n_dropped <= r_n_dropped + 16'd1;
      end

      if (clr) begin
        r_n_deadtime <= '0;
      end else if (w_dt_rej && (r_n_deadtime != 16'hFFFF)) begin
        r_n_deadtime <= r_n_deadtime + 16'd1;
      end
    end
  end

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign n_dropped  = r_n_dropped;
  assign n_deadtime = r_n_deadtime;

endmodule : hit_time_buffer
`default_nettype wire

// File: tb/tb_hit_time_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hit_time_buffer
//  Purpose  : Directed self-checking bench for hit_time_buffer
//             (DEADTIME=2, 16-entry buffer, PRECISION=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hit_time_buffer;
  import hit_time_buffer_pkg::*;

  localparam int P  = 4;
  localparam int TB = tbits(P);
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_in;
  logic [TB-1:0] t_in;
  logic          m_ready;
  logic          clr;
  logic          m_valid;
  logic [TB-1:0] m_data;
  logic [DL:0]   count;
  logic          overflow;
  logic [15:0]   n_dropped;
  logic [15:0]   n_deadtime;

  int total = 0;
  int bad   = 0;

  logic [TB-1:0] exp_q [$];

  hit_time_buffer #(
    .PRECISION  (P),
    .TBITS      (TB),
    .DEPTH_LOG2 (DL),
    .DEADTIME   (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_in   (valid_in),
    .t_in       (t_in),
    .m_ready    (m_ready),
    .clr        (clr),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .count      (count),
    .overflow   (overflow),
    .n_dropped  (n_dropped),
    .n_deadtime (n_deadtime)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TB-1:0] mk(input logic [31:0] ltc, input logic [1:0] idx,
                                       input logic [3:0] sub);
    return {ltc, idx, sub};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [TB-1:0] t);
    t_in     = t;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  // Output monitor: ordering against the expected queue and stall stability.
  logic          stall_prev = 1'b0;
  logic [TB-1:0] data_prev  = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(data_prev));
      end
      if (m_valid && m_ready) begin
        chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("order", 64'(m_data), 64'(exp_q[0]));
          exp_q.delete(0);
        end
      end
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
    end
  end

  initial begin
    logic [TB-1:0] w;
    int n;

    // Reset state
    reset_n = 1'b0; valid_in = 1'b0; t_in = '0; m_ready = 1'b0; clr = 1'b0;
    repeat (3) tick();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_n_dropped", 64'(n_dropped), 64'd0);
    chk("rst_n_deadtime", 64'(n_deadtime), 64'd0);

    // A hit on the first edge after release is ignored
    reset_n = 1'b1;
    t_in = mk(32'd50, 2'd0, 4'd0); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("first_edge_ignored", 64'(count), 64'd0);

    // Single hit latency
    m_ready = 1'b1;
    w = mk(32'h100, 2'd2, 4'h9);
    exp_q.push_back(w);
    hit(w);
    chk("single_count1", 64'(count), 64'd1);
    chk("single_not_yet", 64'(m_valid), 64'd0);
    tick();
    chk("single_valid", 64'(m_valid), 64'd1);
    chk("single_data", 64'(m_data), 64'(w));
    tick();
    chk("single_count0", 64'(count), 64'd0);
    chk("single_drained", 64'(m_valid), 64'd0);

    // Deadtime: 10 accepted, 11 rejected, 12 accepted
    exp_q.push_back(mk(32'd10, 2'd1, 4'h1));
    exp_q.push_back(mk(32'd12, 2'd3, 4'h3));
    hit(mk(32'd10, 2'd1, 4'h1));
    hit(mk(32'd11, 2'd2, 4'h2));
    hit(mk(32'd12, 2'd3, 4'h3));
    chk("dt_n_deadtime", 64'(n_deadtime), 64'd1);
    repeat (4) tick();
    chk("dt_count", 64'(count), 64'd0);
    chk("dt_delivered", 64'(exp_q.size()), 64'd0);

    // LTC wrap: 0xFFFFFFFF then 1 (d=2) accepted, then 2 (d=1) rejected
    exp_q.push_back(mk(32'hFFFF_FFFF, 2'd1, 4'h3));
    exp_q.push_back(mk(32'd1, 2'd0, 4'h5));
    hit(mk(32'hFFFF_FFFF, 2'd1, 4'h3));
    hit(mk(32'd1, 2'd0, 4'h5));
    hit(mk(32'd2, 2'd0, 4'h6));
    chk("wrap_n_deadtime", 64'(n_deadtime), 64'd2);
    repeat (4) tick();
    chk("wrap_delivered", 64'(exp_q.size()), 64'd0);

    // clr beats a same-edge increment; clr keeps the deadtime window
    clr = 1'b1;
    hit(mk(32'd2, 2'd0, 4'h7));
    clr = 1'b0;
    chk("clr_wins", 64'(n_deadtime), 64'd0);
    hit(mk(32'd2, 2'd1, 4'h7));
    chk("clr_keeps_last", 64'(n_deadtime), 64'd1);
    chk("clr_keeps_last_cnt", 64'(count), 64'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_zero", 64'(n_deadtime), 64'd0);

    // Overflow: 20 hits with no reader, 16 kept
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      w = mk(32'd100 + 32'(2 * i), 2'(i), 4'(i));
      if (i < 16) exp_q.push_back(w);
      hit(w);
    end
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_n_dropped", 64'(n_dropped), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head_valid", 64'(m_valid), 64'd1);
    chk("ovf_head_data", 64'(m_data), 64'(exp_q[0]));
    // Write while full with a same-edge read is still dropped
    m_ready = 1'b1;
    hit(mk(32'd140, 2'd0, 4'h0));
    chk("full_rd_wr_drop", 64'(n_dropped), 64'd5);
    chk("full_rd_wr_count", 64'(count), 64'd15);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    chk("ovf_drained", 64'(exp_q.size()), 64'd0);
    chk("ovf_count0", 64'(count), 64'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovf_clr_flag", 64'(overflow), 64'd0);
    chk("ovf_clr_drop", 64'(n_dropped), 64'd0);

    // Random back-pressure
    for (int i = 0; i < 12; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      w = mk(32'd200 + 32'(2 * i), 2'(i), 4'(15 - i));
      exp_q.push_back(w);
      hit(w);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    tick();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_count0", 64'(count), 64'd0);
    chk("bp_no_drop", 64'(n_dropped), 64'd0);

    // Reset mid-stream with 5 words held
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) hit(mk(32'd300 + 32'(2 * i), 2'd0, 4'(i)));
    chk("mid_count5", 64'(count), 64'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_data", 64'(m_data), 64'd0);
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1; m_ready = 1'b1;
    t_in = mk(32'd400, 2'd0, 4'd0); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("mid_first_edge_ignored", 64'(count), 64'd0);
    repeat (4) tick();
    chk("mid_no_stale_valid", 64'(m_valid), 64'd0);
    chk("mid_no_stale_count", 64'(count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hit_time_buffer
`default_nettype wire
